// File: rtl/mfcc_melbank_sched.sv
// rtl/mfcc_melbank_sched.sv - mel filterbank ROM sequencer and per-filter energy accumulator
module mfcc_melbank_sched #(
   parameter int FFT_BINS = 256,
   parameter int BIN_W    = 8,
   parameter int PWR_W    = 32,
   parameter int COEF_W   = 16,
   parameter int FILT_W   = 6,
   parameter int NUM_FILT = 40,
   parameter int ROM_LAT  = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic                       i_s_valid,
   output logic                       o_s_ready,
   input  logic [PWR_W-1:0]           i_s_data,
   output logic [BIN_W-1:0]           o_rom_addr,
   input  logic [FILT_W+COEF_W-1:0]   i_rom_data,
   output logic                       o_m_valid,
   input  logic                       i_m_ready,
   output logic [PWR_W+BIN_W-1:0]     o_m_data,
   output logic [FILT_W-1:0]          o_m_idx,
   output logic                       o_m_last,
   output logic                       o_busy,
   output logic                       o_err
);

   localparam int ACC_W  = PWR_W + COEF_W + BIN_W;
   localparam int PROD_W = PWR_W + COEF_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

   state_t                r_state, w_state_nxt;
   logic [BIN_W-1:0]      r_bin_cnt;
   logic [FILT_W-1:0]     r_cur_m;
   logic [ACC_W-1:0]      r_acc_cur, r_acc_prev;
   logic                  r_err;
   logic                  r_s1_v, r_s2_v;
   logic [PWR_W-1:0]      r_s1_p;
   logic [FILT_W-1:0]     r_s1_m, r_s2_m;
   logic [COEF_W-1:0]     r_s1_w;
   logic [PROD_W-1:0]     r_prod_w, r_prod_c;
   logic                  r_m_valid, r_m_last;
   logic [PWR_W+BIN_W-1:0] r_m_data;
   logic [FILT_W-1:0]     r_m_idx;

   logic                  w_en, w_accept, w_start_acc, w_flush_load, w_last_bin;
   logic [COEF_W:0]       w_comp;
   logic [FILT_W:0]       w_next_m;
   logic [BIN_W-1:0]      w_rom_addr;

   // a held output word freezes the whole pipeline
   assign w_en         = !(r_m_valid && !i_m_ready);
   assign o_s_ready    = (r_state == S_RUN) && w_en;
   assign w_accept     = i_s_valid && o_s_ready;
   assign w_start_acc  = (r_state == S_IDLE) && i_start;
   assign w_last_bin   = (r_bin_cnt == BIN_W'(FFT_BINS - 1));
   assign w_flush_load = (r_state == S_DRAIN) && !r_s1_v && !r_s2_v && w_en;
   assign w_comp       = {1'b1, {COEF_W{1'b0}}} - {1'b0, r_s1_w};
   assign w_next_m     = {1'b0, r_cur_m} + (FILT_W+1)'(1);

   assign o_m_valid = r_m_valid;
   assign o_m_data  = r_m_data;
   assign o_m_idx   = r_m_idx;
   assign o_m_last  = r_m_last;
   assign o_busy    = (r_state != S_IDLE);
   assign o_err     = r_err;
   assign o_rom_addr = w_rom_addr;

   // ROM address: prefetch next bin on accept when the ROM output is registered
   always_comb begin
      w_rom_addr = '0;
      if (r_state != S_IDLE) begin
         if (ROM_LAT != 0 && w_accept) w_rom_addr = r_bin_cnt + BIN_W'(1);
         else                          w_rom_addr = r_bin_cnt;
      end
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && w_last_bin) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_flush_load) w_state_nxt = S_FLUSH;
         S_FLUSH: if (r_m_valid && i_m_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // S0 capture and S1 weight multiply, both frozen while stalled
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
      end else if (w_en) begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_p <= i_s_data;
            r_s1_m <= i_rom_data[FILT_W+COEF_W-1:COEF_W];
            r_s1_w <= i_rom_data[COEF_W-1:0];
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_prod_w <= PROD_W'(r_s1_p) * PROD_W'(r_s1_w);
            r_prod_c <= PROD_W'(r_s1_p) * PROD_W'(w_comp);
            r_s2_m   <= r_s1_m;
         end
      end
   end

   // S2 accumulate, filter hand-over, flush word and output register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_bin_cnt  <= '0;
         r_cur_m    <= '0;
         r_acc_cur  <= '0;
         r_acc_prev <= '0;
         r_err      <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_last   <= 1'b0;
         r_m_data   <= '0;
         r_m_idx    <= '0;
      end else begin
         if (r_m_valid && i_m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
         end
         if (w_start_acc) begin
            r_bin_cnt  <= '0;
            r_cur_m    <= '0;
            r_acc_cur  <= '0;
            r_acc_prev <= '0;
            r_err      <= 1'b0;
         end
         if (w_accept) r_bin_cnt <= r_bin_cnt + BIN_W'(1);
         if (w_en && r_s2_v) begin
            if (r_s2_m == r_cur_m) begin
               r_acc_cur  <= r_acc_cur + ACC_W'(r_prod_w);
               r_acc_prev <= r_acc_prev + ACC_W'(r_prod_c);
            end else if ({1'b0, r_s2_m} == w_next_m) begin
               if (r_cur_m != '0) begin
                  r_m_valid <= 1'b1;
                  r_m_last  <= 1'b0;
                  r_m_data  <= r_acc_prev[ACC_W-1:COEF_W];
                  r_m_idx   <= r_cur_m - FILT_W'(1);
               end
               r_acc_prev <= r_acc_cur + ACC_W'(r_prod_c);
               r_acc_cur  <= ACC_W'(r_prod_w);
               r_cur_m    <= r_s2_m;
            end else begin
               r_err <= 1'b1;
            end
         end
         if (w_flush_load) begin
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b1;
            r_m_data  <= r_acc_prev[ACC_W-1:COEF_W];
            r_m_idx   <= r_cur_m - FILT_W'(1);
            if (r_cur_m != FILT_W'(NUM_FILT)) r_err <= 1'b1;
         end
      end
   end

endmodule
